// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared widths and FSM state encoding for the FIFO-drain UART TX.
// Revision: 1.0
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_W    = 8;
    localparam int UART_STOP_BITS = 1;
    localparam int UART_IDX_W     = $clog2(UART_DATA_W);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ============================================================================
// Module  : uart_baud_cnt
// Brief   : Bit-period counter; tick marks the last cycle of each bit period.
// Revision: 1.0
// ============================================================================
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clear || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module  : fifo_uart_tx
// Brief   : Pops bytes from an 8-bit FIFO and sends each as a UART 8N1 frame.
// Revision: 1.0
// ============================================================================
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 125_000_000,
    parameter int BAUD         = 115_200,
    parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   fifo_empty,
    input  logic [UART_DATA_W-1:0] fifo_data,
    output logic                   fifo_rd_en,
    output logic                   tx,
    output logic                   busy,
    output logic [15:0]            frame_count
);

    if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
        $error("fifo_uart_tx: CLKS_PER_BIT must be >= 4");
    end

    localparam logic [UART_IDX_W-1:0] c_last_data = UART_IDX_W'(UART_DATA_W - 1);
    localparam logic [UART_IDX_W-1:0] c_last_stop = UART_IDX_W'(UART_STOP_BITS - 1);

    uart_state_t            r_state;
    uart_state_t            w_state_next;
    logic [UART_DATA_W-1:0] r_shift;
    logic [UART_DATA_W-1:0] w_shift_next;
    logic [UART_IDX_W-1:0]  r_bit_idx;
    logic [UART_IDX_W-1:0]  w_bit_idx_next;
    logic                   r_tx;
    logic                   w_tx_next;
    logic                   r_rd_en;
    logic                   w_rd_en_next;
    logic [15:0]            r_frame_count;
    logic [15:0]            w_frame_count_next;
    logic                   w_tick;
    logic                   w_clear;

    // Restart the bit period on every state change; keep it parked while idle.
    assign w_clear = (w_state_next != r_state) || (r_state == IDLE);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk  (clk),
        .rst  (rst),
        .clear(w_clear),
        .tick (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_shift       <= '0;
            r_bit_idx     <= '0;
            r_tx          <= 1'b1;
            r_rd_en       <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_state       <= w_state_next;
            r_shift       <= w_shift_next;
            r_bit_idx     <= w_bit_idx_next;
            r_tx          <= w_tx_next;
            r_rd_en       <= w_rd_en_next;
            r_frame_count <= w_frame_count_next;
        end
    end

    // tx is computed one cycle ahead so the line level lands with the state.
    always_comb begin
        w_state_next       = r_state;
        w_shift_next       = r_shift;
        w_bit_idx_next     = r_bit_idx;
        w_tx_next          = r_tx;
        w_rd_en_next       = 1'b0;
        w_frame_count_next = r_frame_count;
        case (r_state)
            IDLE: begin
                w_tx_next = 1'b1;
                if (en && !fifo_empty) begin
                    w_state_next = FETCH;
                    w_rd_en_next = 1'b1;
                end
            end
            FETCH: begin
                w_state_next = LOAD;
            end
            LOAD: begin
                w_shift_next   = fifo_data;
                w_bit_idx_next = '0;
                w_tx_next      = 1'b0;
                w_state_next   = START;
            end
            START: begin
                if (w_tick) begin
                    w_tx_next    = r_shift[0];
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_bit_idx == c_last_data) begin
                        w_bit_idx_next = '0;
                        w_tx_next      = 1'b1;
                        w_state_next   = STOP;
                    end else begin
                        w_shift_next   = r_shift >> 1;
                        w_tx_next      = r_shift[1];
                        w_bit_idx_next = r_bit_idx + 1'b1;
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (r_bit_idx == c_last_stop) begin
                        w_bit_idx_next     = '0;
                        w_frame_count_next = r_frame_count + 16'd1;
                        w_state_next       = IDLE;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_tx_next    = 1'b1;
                w_state_next = IDLE;
            end
        endcase
    end

    assign tx          = r_tx;
    assign fifo_rd_en  = r_rd_en;
    assign busy        = (r_state != IDLE);
    assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_uart_tx
// Brief   : Self-checking bench for fifo_uart_tx fed by a behavioural 8-deep FIFO.
// Revision: 1.0
// ============================================================================
module tb_fifo_uart_tx;

    localparam int BIT_CYC = 16;              // 1600 Hz / 100 baud
    localparam int GAP     = 10 * BIT_CYC + 3;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // frame[0] = start bit, frame[9] = stop bit
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        fifo_empty;
    logic [7:0]  fifo_data;
    logic        fifo_rd_en;
    logic        tx;
    logic        busy;
    logic [15:0] frame_count;

    logic        fifo_rst = 1'b1;
    logic        f_wr = 1'b0;
    logic [7:0]  f_wdata = 8'h00;
    logic [7:0]  f_mem [8];
    logic [3:0]  f_cnt;
    logic [2:0]  f_wp;
    logic [2:0]  f_rp;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int rd_cyc = 0;
    logic [7:0] sb[$];
    vec_t vecs[9];

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .CLK_HZ(1600),
        .BAUD  (100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .tx         (tx),
        .busy       (busy),
        .frame_count(frame_count)
    );

    assign fifo_empty = (f_cnt == 4'd0);

    always @(posedge clk) begin
        if (fifo_rst) begin
            f_cnt     <= 4'd0;
            f_wp      <= 3'd0;
            f_rp      <= 3'd0;
            fifo_data <= 8'h00;
        end else begin
            if (f_wr && f_cnt != 4'd8) begin
                f_mem[f_wp] <= f_wdata;
                f_wp        <= f_wp + 3'd1;
            end
            if (fifo_rd_en && f_cnt != 4'd0) begin
                fifo_data <= f_mem[f_rp];
                f_rp      <= f_rp + 3'd1;
            end
            case ({f_wr && f_cnt != 4'd8, fifo_rd_en && f_cnt != 4'd0})
                2'b10:   f_cnt <= f_cnt + 4'd1;
                2'b01:   f_cnt <= f_cnt - 4'd1;
                default: f_cnt <= f_cnt;
            endcase
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fifo_rd_en) begin
            rd_cnt = rd_cnt + 1;
            rd_cyc = cyc;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        @(negedge clk);
        f_wr    = 1'b1;
        f_wdata = b;
        @(negedge clk);
        f_wr    = 1'b0;
        sb.push_back(b);
    endtask

    task automatic wait_start(output bit ok);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx !== 1'b0 && n < 3000);
        ok = (tx === 1'b0);
        if (!ok) chk("start_timeout", 32'(tx), 32'd0);
    endtask

    // Samples all 160 cycles of a frame starting at the first START cycle.
    task automatic recv_frame(input bit drop_en, output logic [9:0] bits,
                              output bit ok, output int t_start);
        bit glitch;
        glitch  = 1'b0;
        bits    = '0;
        t_start = 0;
        wait_start(ok);
        if (ok) begin
            t_start = cyc;
            for (int b = 0; b < 10; b++) begin
                for (int c = 0; c < BIT_CYC; c++) begin
                    if (b != 0 || c != 0) @(negedge clk);
                    if (drop_en && b == 9 && c == BIT_CYC / 2) en = 1'b0;
                    if (c == 0) bits[b] = tx;
                    else if (tx !== bits[b]) glitch = 1'b1;
                end
            end
            chk("bit_level_stable", 32'(glitch), 32'd0);
        end
    endtask

    task automatic check_frame(input logic [9:0] exp_frame, input bit drop_en,
                               output int t_start);
        logic [9:0] bits;
        logic [7:0] exp_b;
        bit ok;
        recv_frame(drop_en, bits, ok, t_start);
        if (ok) begin
            chk("frame_bits", 32'(bits), 32'(exp_frame));
            if (sb.size() == 0) begin
                chk("scoreboard_nonempty", 32'(sb.size()), 32'd1);
            end else begin
                exp_b = sb.pop_front();
                chk("frame_byte", 32'(bits[8:1]), 32'(exp_b));
            end
        end
    endtask

    initial begin
        int t0;
        int tprev;
        int rd0;
        bit ok;
        bit bad_tx;
        bit bad_busy;

        vecs[0] = '{8'hAA, 10'h354};
        vecs[1] = '{8'hF0, 10'h3E0};
        vecs[2] = '{8'h09, 10'h212};
        vecs[3] = '{8'hAA, 10'h354};
        vecs[4] = '{8'hA9, 10'h352};
        vecs[5] = '{8'h00, 10'h200};
        vecs[6] = '{8'hFF, 10'h3FE};
        vecs[7] = '{8'h55, 10'h2AA};
        vecs[8] = '{8'hAA, 10'h354};

        // Reset values
        repeat (2) @(negedge clk);
        fifo_rst = 1'b0;
        chk("rst_hold_tx", 32'(tx), 32'd1);
        chk("rst_hold_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_frame_count", 32'(frame_count), 32'd0);

        // Single byte
        rd0 = rd_cnt;
        push_byte(vecs[0].data);
        en = 1'b1;
        check_frame(vecs[0].frame, 1'b0, t0);
        chk("single_latency", 32'(t0 - rd_cyc), 32'd2);
        repeat (2) @(negedge clk);
        chk("single_rd_pulses", 32'(rd_cnt - rd0), 32'd1);
        chk("single_frame_count", 32'(frame_count), 32'd1);
        chk("single_fifo_empty", 32'(fifo_empty), 32'd1);
        chk("single_busy_after", 32'(busy), 32'd0);

        // Burst of eight, FIFO filled before draining starts
        do_reset();
        rd0 = rd_cnt;
        for (int i = 1; i <= 8; i++) push_byte(vecs[i].data);
        chk("burst_fifo_full", 32'(f_cnt), 32'd8);
        en = 1'b1;
        tprev = 0;
        for (int i = 1; i <= 8; i++) begin
            check_frame(vecs[i].frame, 1'b0, t0);
            if (i > 1) chk("burst_gap", 32'(t0 - tprev), 32'(GAP));
            tprev = t0;
        end
        repeat (2) @(negedge clk);
        chk("burst_rd_pulses", 32'(rd_cnt - rd0), 32'd8);
        chk("burst_frame_count", 32'(frame_count), 32'd8);
        chk("burst_fifo_empty", 32'(fifo_empty), 32'd1);

        // Starvation: enabled with nothing to send
        rd0 = rd_cnt;
        bad_tx = 1'b0;
        bad_busy = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) bad_tx = 1'b1;
            if (busy !== 1'b0) bad_busy = 1'b1;
        end
        chk("starve_rd_pulses", 32'(rd_cnt - rd0), 32'd0);
        chk("starve_tx_high", 32'(bad_tx), 32'd0);
        chk("starve_busy_low", 32'(bad_busy), 32'd0);

        // Reset in the middle of data bit 3 of 0xF0
        do_reset();
        push_byte(vecs[1].data);
        push_byte(vecs[2].data);
        en = 1'b1;
        wait_start(ok);
        if (ok) begin
            repeat (4 * BIT_CYC + BIT_CYC / 2) @(negedge clk);
            chk("midrst_bit3_low", 32'(tx), 32'd0);
            chk("midrst_busy", 32'(busy), 32'd1);
            #2 rst = 1'b1;
            #1;
            chk("midrst_tx_async", 32'(tx), 32'd1);
            chk("midrst_busy_async", 32'(busy), 32'd0);
            chk("midrst_count_async", 32'(frame_count), 32'd0);
            void'(sb.pop_front());
            repeat (2) @(negedge clk);
            rst = 1'b0;
            check_frame(vecs[2].frame, 1'b0, t0);
            repeat (2) @(negedge clk);
            chk("midrst_frame_count", 32'(frame_count), 32'd1);
        end

        // Enable dropped during the stop bit of the first of three frames
        do_reset();
        sb.delete();
        push_byte(vecs[1].data);
        push_byte(vecs[2].data);
        push_byte(vecs[7].data);
        rd0 = rd_cnt;
        en = 1'b1;
        check_frame(vecs[1].frame, 1'b1, t0);
        repeat (40) @(negedge clk);
        chk("endrop_rd_pulses", 32'(rd_cnt - rd0), 32'd1);
        chk("endrop_fifo_level", 32'(f_cnt), 32'd2);
        chk("endrop_busy", 32'(busy), 32'd0);
        chk("endrop_tx_idle", 32'(tx), 32'd1);
        chk("endrop_frame_count", 32'(frame_count), 32'd1);
        en = 1'b1;
        check_frame(vecs[2].frame, 1'b0, t0);
        check_frame(vecs[7].frame, 1'b0, t0);
        repeat (2) @(negedge clk);
        chk("resume_rd_pulses", 32'(rd_cnt - rd0), 32'd3);
        chk("resume_frame_count", 32'(frame_count), 32'd3);
        chk("resume_fifo_empty", 32'(fifo_empty), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
